// File: rtl/uart_tx_engine_if.sv
// Processor-side load handshake for the UART transmit engine.
// LOAD/DATA_IN from the register block, TXRDY back to it.
interface uart_tx_engine_if;
  logic       LOAD;
  logic [7:0] DATA_IN;
  logic       TXRDY;

  modport master (
    output LOAD,
    output DATA_IN,
    input  TXRDY
  );

  modport slave (
    input  LOAD,
    input  DATA_IN,
    output TXRDY
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: 11-bit-time frames, LSB first, optional parity.
// Optional one-entry holding buffer under `define UART_TX_HOLD_BUF_EN.
module uart_tx_engine (
  input  logic              clk,
  input  logic              rst,
  input  logic [18:0]       k,
  input  logic              EIGHT,
  input  logic              PEN,
  input  logic              OHEL,
  uart_tx_engine_if.slave   bus,
  output logic              TX
);

  localparam int FRAME_BITS = 11;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [18:0]             r_cnt;
  logic [18:0]             w_cnt_nxt;
  logic [3:0]              r_bitcnt;
  logic [3:0]              w_bitcnt_nxt;
  logic [FRAME_BITS-1:0]   r_shift;
  logic [FRAME_BITS-1:0]   w_shift_nxt;
  logic [FRAME_BITS-1:0]   w_frame;
  logic [18:0]             w_klim;
  logic                    w_btu;
  logic                    w_last;
  logic                    w_accept;

`ifdef UART_TX_HOLD_BUF_EN
  logic [FRAME_BITS-1:0]   r_hold;
  logic [FRAME_BITS-1:0]   w_hold_nxt;
  logic                    r_hold_full;
  logic                    w_hold_full_nxt;
`endif

  // Whole frame is built at load time, which freezes the config for it.
  function automatic logic [FRAME_BITS-1:0] f_frame(
    input logic [7:0] d,
    input logic       eight,
    input logic       pen,
    input logic       ohel
  );
    logic                  p;
    logic [FRAME_BITS-1:0] f;
    p = (eight ? ^d : ^d[6:0]) ^ ohel;
    if (eight)
      f = {1'b1, (pen ? p : 1'b1), d, 1'b0};
    else
      f = {2'b11, (pen ? p : 1'b1), d[6:0], 1'b0};
    return f;
  endfunction

  assign w_frame = f_frame(bus.DATA_IN, EIGHT, PEN, OHEL);

  // k of 0 behaves as 1; >= keeps a shrunken k from stalling the count.
  assign w_klim = (k == 19'd0) ? 19'd0 : k - 19'd1;
  assign w_btu  = (r_state == SHIFT) && (r_cnt >= w_klim);
  assign w_last = w_btu && (r_bitcnt == 4'(FRAME_BITS - 1));

`ifdef UART_TX_HOLD_BUF_EN
  assign bus.TXRDY = ~r_hold_full;
`else
  assign bus.TXRDY = (r_state == IDLE);
`endif

  assign w_accept = bus.LOAD && bus.TXRDY;
  assign TX       = r_shift[0];

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
`ifdef UART_TX_HOLD_BUF_EN
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
`endif
    unique case (1'b1)
      (r_state == IDLE): begin
        if (w_accept) begin
          w_state_nxt  = SHIFT;
          w_shift_nxt  = w_frame;
          w_cnt_nxt    = 19'd0;
          w_bitcnt_nxt = 4'd0;
        end
      end
      (r_state == SHIFT): begin
        if (!w_btu) begin
          w_cnt_nxt = r_cnt + 19'd1;
        end else if (!w_last) begin
          w_cnt_nxt    = 19'd0;
          w_bitcnt_nxt = r_bitcnt + 4'd1;
          w_shift_nxt  = {1'b1, r_shift[FRAME_BITS-1:1]};
        end else begin
          w_cnt_nxt    = 19'd0;
          w_bitcnt_nxt = 4'd0;
`ifdef UART_TX_HOLD_BUF_EN
          if (r_hold_full) begin
            w_shift_nxt     = r_hold;
            w_hold_full_nxt = 1'b0;
          end else if (w_accept) begin
            w_shift_nxt = w_frame;
          end else begin
            w_state_nxt = IDLE;
            w_shift_nxt = '1;
          end
`else
          w_state_nxt = IDLE;
          w_shift_nxt = '1;
`endif
        end
`ifdef UART_TX_HOLD_BUF_EN
        if (w_accept && !w_last) begin
          w_hold_nxt      = w_frame;
          w_hold_full_nxt = 1'b1;
        end
`endif
      end
      default: begin
        w_state_nxt = IDLE;
        w_shift_nxt = '1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= 19'd0;
      r_bitcnt <= 4'd0;
      r_shift  <= '1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
    end
  end

`ifdef UART_TX_HOLD_BUF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold      <= '1;
      r_hold_full <= 1'b0;
    end else begin
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed testbench for uart_tx_engine.
// Frames written first-bit-leftmost as 11-bit literals.
module tb_uart_tx_engine;

  logic        clk;
  logic        rst;
  logic [18:0] k;
  logic        EIGHT;
  logic        PEN;
  logic        OHEL;
  logic        TX;

  int n_cmp;
  int n_fail;

`ifdef UART_TX_HOLD_BUF_EN
  localparam logic RDY_BUSY = 1'b1;
`else
  localparam logic RDY_BUSY = 1'b0;
`endif

  uart_tx_engine_if u_if ();

  uart_tx_engine u_dut (
    .clk   (clk),
    .rst   (rst),
    .k     (k),
    .EIGHT (EIGHT),
    .PEN   (PEN),
    .OHEL  (OHEL),
    .bus   (u_if),
    .TX    (TX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse LOAD, check every clock of the frame, then the idle return.
  task automatic run_frame(input string tag, input logic [7:0] d,
                           input logic [10:0] seq, input int kk,
                           input int extra);
    u_if.DATA_IN = d;
    u_if.LOAD    = 1'b1;
    for (int c = 0; c < 11 * kk; c++) begin
      step();
      if (c == 0) u_if.LOAD = 1'b0;
      if (extra >= 0 && c == extra + 1) u_if.LOAD = 1'b0;
      chk({tag, "_tx"}, 32'(TX), 32'(seq[10 - c / kk]));
      chk({tag, "_rdy"}, 32'(u_if.TXRDY), 32'(RDY_BUSY));
      if (extra >= 0 && c == extra) begin
        u_if.DATA_IN = 8'hFF;
        u_if.LOAD    = 1'b1;
      end
    end
    step();
    chk({tag, "_end_tx"}, 32'(TX), 32'd1);
    chk({tag, "_end_rdy"}, 32'(u_if.TXRDY), 32'd1);
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    rst          = 1'b0;
    k            = 19'd4;
    EIGHT        = 1'b1;
    PEN          = 1'b1;
    OHEL         = 1'b0;
    u_if.LOAD    = 1'b0;
    u_if.DATA_IN = 8'h00;

    // 1: reset and idle
    repeat (3) begin
      step();
      chk("rst_tx", 32'(TX), 32'd1);
      chk("rst_rdy", 32'(u_if.TXRDY), 32'd1);
    end
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle_tx", 32'(TX), 32'd1);
      chk("idle_rdy", 32'(u_if.TXRDY), 32'd1);
    end

    // 2: 8 data bits, even parity
    run_frame("f55", 8'h55, 11'b01010101001, 4, -1);

    // 3: 7 data bits, odd parity
    k = 19'd3; EIGHT = 1'b0; PEN = 1'b1; OHEL = 1'b1;
    run_frame("fC3", 8'hC3, 11'b01100001011, 3, -1);

    // 4: no parity, stray LOAD mid-frame
    k = 19'd2; EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
    run_frame("fA5", 8'hA5, 11'b01010010111, 2, -1);
`else
    run_frame("fA5", 8'hA5, 11'b01010010111, 2, 4);
`endif
    for (int i = 0; i < 30; i++) begin
      step();
      chk("no2nd_tx", 32'(TX), 32'd1);
    end

    // 5: reset mid-frame, then a clean frame
    k = 19'd4; EIGHT = 1'b1; PEN = 1'b1; OHEL = 1'b0;
    u_if.DATA_IN = 8'h0F;
    u_if.LOAD    = 1'b1;
    step();
    u_if.LOAD = 1'b0;
    for (int i = 1; i < 20; i++) step();
    chk("pre_rst_tx", 32'(TX), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(TX), 32'd1);
    chk("mid_rst_rdy", 32'(u_if.TXRDY), 32'd1);
    step();
    rst = 1'b1;
    step();
    run_frame("f0F", 8'h0F, 11'b01111000001, 4, -1);

`ifndef UART_TX_HOLD_BUF_EN
    // k shrunk mid-frame must still end the frame
    begin
      int waited;
      k = 19'd8;
      u_if.DATA_IN = 8'h33;
      u_if.LOAD    = 1'b1;
      step();
      u_if.LOAD = 1'b0;
      repeat (20) step();
      k = 19'd2;
      waited = 0;
      while (u_if.TXRDY !== 1'b1 && waited < 300) begin
        step();
        waited++;
      end
      chk("kchg_done", 32'(u_if.TXRDY), 32'd1);
      chk("kchg_tx", 32'(TX), 32'd1);
    end
`endif

`ifdef UART_TX_HOLD_BUF_EN
    // 6: back-to-back frames through the holding register
    begin
      logic [21:0] seq2;
      seq2 = {11'b01000000011, 11'b00100000011};
      k = 19'd2; EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0;
      u_if.DATA_IN = 8'h01;
      u_if.LOAD    = 1'b1;
      for (int c = 0; c < 44; c++) begin
        step();
        if (c == 0 || c == 4) u_if.LOAD = 1'b0;
        chk("hb_tx", 32'(TX), 32'(seq2[21 - c / 2]));
        if (c == 4) chk("hb_rdy_lo", 32'(u_if.TXRDY), 32'd0);
        if (c == 22) chk("hb_rdy_hi", 32'(u_if.TXRDY), 32'd1);
        if (c == 3) begin
          u_if.DATA_IN = 8'h02;
          u_if.LOAD    = 1'b1;
        end
      end
      step();
      chk("hb_end_tx", 32'(TX), 32'd1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Transmit engine of the UART; counterpart of the receive engine and shares its configuration inputs (EIGHT, PEN, OHEL, k).
- Accepts a byte from the processor-side register interface with a LOAD strobe.
- Serialises the byte LSB-first onto TX as a fixed 11-bit-time frame: start bit, data, optional parity, stop/pad bits.
- Sits beside the receive engine in the UART top level; TXRDY feeds the status/interrupt logic.

Parameters:
- FRAME_BITS, 11, bit times per frame, including start and all stop/pad bits. Fixed; not for override.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low (0 = reset)
- k  input  19  clocks per bit time; 0 is treated as 1
- EIGHT  input  1  1 = 8 data bits, 0 = 7 data bits (DATA_IN[7] ignored)
- PEN  input  1  parity enable
- OHEL  input  1  parity sense: 0 = even, 1 = odd
- LOAD  input  1  one-cycle strobe; accept DATA_IN when TXRDY=1
- DATA_IN  input  8  byte to transmit
- TX  output  1  serial line, idles high
- TXRDY  output  1  1 = engine can accept a LOAD

Behaviour:
- Reset (rst=0, asynchronous): TX=1, TXRDY=1, bit-time counter=0, bit counter=0, shift register all 1s, state IDLE.
- States:
  - IDLE: TX=1. On LOAD=1 && TXRDY=1, go to SHIFT at the next edge.
  - SHIFT: frame transmission in progress.
  - Return from SHIFT to IDLE after bit 10's bit time completes.
- Load edge:
  - Latch EIGHT, PEN and OHEL; config changes mid-frame have no effect.
  - Load the 11-bit shift register and drive TX = start bit (0) on the same edge.
  - TXRDY=0 from that edge.
  - Latency: LOAD sampled at edge N produces TX=0 after edge N.
- Frame order after the start bit (P = parity over the transmitted data bits only):
  - EIGHT=1, PEN=1: D0..D7, P, 1
  - EIGHT=1, PEN=0: D0..D7, 1, 1
  - EIGHT=0, PEN=1: D0..D6, P, 1, 1
  - EIGHT=0, PEN=0: D0..D6, 1, 1, 1
- Parity: even (OHEL=0) gives P = XOR of the data bits; odd (OHEL=1) gives P = ~XOR.
- Bit timing:
  - Bit-time counter counts 0..k-1.
  - BTU asserts when count == k-1; the counter wraps to 0.
  - On BTU: shift register shifts right, filling with 1; the bit counter increments.
  - Each bit is held exactly max(k,1) clocks.
- End of frame: on the BTU that ends bit 10 (bit counter == 10):
  - state returns to IDLE, TXRDY=1, TX=1, counters cleared.
- Boundary conditions:
  - LOAD while TXRDY=0: ignored; no effect on data or timing.
  - LOAD in the same cycle as the final BTU: ignored, because TXRDY is still 0 that cycle. It is accepted from the next cycle.
  - LOAD held high continuously: one frame per acceptance, with 1 idle clock between frames.
  - rst asserted mid-frame: TX returns high immediately; the partial frame is abandoned.
  - k changed mid-frame: the new value takes effect on the next count comparison. Not a supported use; the bench only checks that there is no lockup.

Optional Feature:
- Macro: UART_TX_HOLD_BUF_EN
- With the macro defined:
  - Adds a one-entry holding register, with a full flag, in front of the shift register.
  - TXRDY = ~hold_full, so LOAD is accepted during SHIFT if the holding register is empty.
  - At the final BTU, if hold_full, the held byte moves into the shift register on that same edge, using config latched at its LOAD.
  - TX goes straight from the stop bit to the next start bit with zero idle clocks; hold_full clears and TXRDY rises.
  - LOAD while hold_full: ignored.
  - Reset clears hold_full.
- Without the macro: no holding register; TXRDY is low for the whole frame, as described in Behaviour.

Test Plan:
1. Reset then idle, k=4 → TX=1 and TXRDY=1 throughout reset and 50 clocks after it.
2. k=4, EIGHT=1, PEN=1, OHEL=0, LOAD DATA_IN=0x55 → TX sequence 0,1,0,1,0,1,0,1,0,0,1, each bit held 4 clocks; TXRDY low for 44 clocks, then high.
3. k=3, EIGHT=0, PEN=1, OHEL=1, DATA_IN=0xC3 (D0..D6=1,1,0,0,0,0,1) → start 0, data 1,1,0,0,0,0,1, P=0 (odd), then 1,1; 33 clocks total.
4. k=2, EIGHT=1, PEN=0, LOAD 0xA5, then LOAD 0xFF 5 clocks later → second LOAD ignored; frame is 0, 1,0,1,0,0,1,0,1, 1,1, and no second frame follows.
5. k=4, rst pulled low at clock 20 of a frame → TX=1 and TXRDY=1 within the same cycle. A new LOAD of 0x0F then produces a clean full frame.
6. Only with UART_TX_HOLD_BUF_EN, k=2: LOAD 0x01, then LOAD 0x02 while shifting → TXRDY drops, then rises at the end of frame 1. Frame 2's start bit immediately follows frame 1's stop bit with 0 idle clocks.
